// File: rtl/conv5x5_bin_engine.sv
// Binary 5x5 sliding-window engine: latches kernel, streams raster pixels, emits match counts.
// Optional CONV_XNOR_EN: products become XNOR (BNN match count) instead of AND.
module conv5x5_bin_engine #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        kernal_ok,
    input  logic [24:0] kernal_data,
    input  logic        pix_valid,
    input  logic        pix_data,
    output logic        busy,
    output logic        out_valid,
    output logic [4:0]  out_data,
    output logic [4:0]  out_row,
    output logic [4:0]  out_col,
    output logic        frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic [24:0]            kern_q;
    logic [3:0][IMG_W-1:0]  lb_q;
    logic [4:0][4:0]        win_q;
    logic [4:0][4:0]        win_d;
    logic [CW-1:0]          col_q;
    logic [RW-1:0]          row_q;
    logic                   busy_q;
    logic                   ov_q;
    logic                   fd_q;
    logic [4:0]             data_q;
    logic [4:0]             orow_q;
    logic [4:0]             ocol_q;

    logic                   accept;
    logic                   last_pix;
    logic                   win_ok;
    logic [24:0]            prod;
    logic [4:0]             sum_d;

    always_comb begin
        accept   = (state_q == S_RUN) && pix_valid;
        last_pix = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
        win_ok   = (row_q >= RW'(4)) && (col_q >= CW'(4));
        // Packed [r][c] puts w[r][c] at bit r*5+c, matching the kernel bit order.
        win_d[0] = {lb_q[3][col_q], win_q[0][4:1]};
        win_d[1] = {lb_q[2][col_q], win_q[1][4:1]};
        win_d[2] = {lb_q[1][col_q], win_q[2][4:1]};
        win_d[3] = {lb_q[0][col_q], win_q[3][4:1]};
        win_d[4] = {pix_data,       win_q[4][4:1]};
`ifdef CONV_XNOR_EN
        prod = ~(win_d ^ kern_q);
`else
        prod = win_d & kern_q;
`endif
        sum_d = '0;
        for (int k = 0; k < 25; k++) begin
            sum_d = sum_d + 5'(prod[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            kern_q  <= '0;
            lb_q    <= '0;
            win_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            busy_q  <= 1'b0;
            ov_q    <= 1'b0;
            fd_q    <= 1'b0;
            data_q  <= '0;
            orow_q  <= '0;
            ocol_q  <= '0;
        end else begin
            ov_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (kernal_ok) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    kern_q  <= kernal_data;
                    col_q   <= '0;
                    row_q   <= '0;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (accept) begin
                        win_q            <= win_d;
                        lb_q[0][col_q]   <= pix_data;
                        lb_q[1][col_q]   <= lb_q[0][col_q];
                        lb_q[2][col_q]   <= lb_q[1][col_q];
                        lb_q[3][col_q]   <= lb_q[2][col_q];
                        ov_q             <= win_ok;
                        if (win_ok) begin
                            data_q <= sum_d;
                            orow_q <= 5'(row_q - RW'(4));
                            ocol_q <= 5'(col_q - CW'(4));
                        end
                        if (col_q == CW'(IMG_W - 1)) begin
                            col_q <= '0;
                            row_q <= last_pix ? '0 : row_q + RW'(1);
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                        if (last_pix) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            fd_q    <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    fd_q    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign out_valid  = ov_q;
    assign out_data   = data_q;
    assign out_row    = orow_q;
    assign out_col    = ocol_q;
    assign frame_done = fd_q;

endmodule
